// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- load/store stage between EX and writeback.
//
// Takes one EX result per accepted cycle. Non-memory ops write back Result one
// cycle later. Misaligned loads and stores raise AddrErr. Aligned loads and
// stores issue a single request on the memory bus and wait for MemAck. If the
// ack does not arrive within TIMEOUT cycles, BusErr is raised instead.
//
// Parameters
//   TIMEOUT   max cycles MemReq stays high waiting for MemAck (>= 1)
//
// Ports
//   CLK       clock, rising edge
//   RST       asynchronous active-low reset
//   Valid     EX result valid (sampled only while idle)
//   Ins       instruction, opcode in Ins[31:26]
//   Result    EX result / effective address
//   Rdata2    store data (rt)
//   Busy      stage occupied, upstream must hold
//   MemReq    memory request, held until the cycle MemAck is seen
//   MemWE     write enable (stores)
//   MemAddr   word address
//   MemBE     byte-lane enables, bit i = lane i (little-endian)
//   MemWdata  store data replicated across lanes
//   MemAck    memory completion, MemRdata valid in the same cycle
//   MemRdata  read data
//   WBdata    writeback data, holds its value between strobes
//   WBvalid   one-cycle writeback strobe
//   AddrErr   one-cycle misalignment strobe
//   BusErr    one-cycle memory timeout strobe
// -----------------------------------------------------------------------------
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Valid,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Busy,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWdata,
    input  logic        MemAck,
    input  logic [31:0] MemRdata,
    output logic [31:0] WBdata,
    output logic        WBvalid,
    output logic        AddrErr,
    output logic        BusErr
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          store_q;
    logic          signed_q;
    mem_size_t     size_q;
    logic [1:0]    off_q;

    // Only the opcode field matters to this stage.
    logic unused_ins;
    assign unused_ins = ^Ins[25:0];

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    logic      is_mem, is_store, is_signed, misaligned;
    mem_size_t size;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        is_mem    = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_WORD;
        case (Ins[31:26])
            OP_LB:  begin size = SZ_BYTE; is_signed = 1'b1; end
            OP_LH:  begin size = SZ_HALF; is_signed = 1'b1; end
            OP_LW:  size = SZ_WORD;
            OP_LBU: size = SZ_BYTE;
            OP_LHU: size = SZ_HALF;
            OP_SB:  begin size = SZ_BYTE; is_store = 1'b1; end
            OP_SH:  begin size = SZ_HALF; is_store = 1'b1; end
            OP_SW:  begin size = SZ_WORD; is_store = 1'b1; end
            default: is_mem = 1'b0;
        endcase
        misaligned = is_mem && ((size == SZ_HALF && Result[0]) ||
                                (size == SZ_WORD && Result[1:0] != 2'b00));
    end

    // Lane enables and replicated store data for the request being accepted.
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    always_comb begin
        case (size)
            SZ_BYTE: begin
                be_d    = 4'b0001 << Result[1:0];
                wdata_d = {4{Rdata2[7:0]}};
            end
            SZ_HALF: begin
                be_d    = Result[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{Rdata2[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = Rdata2;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction from the lane selected by the latched offset
    // ------------------------------------------------------------------
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    always_comb begin
        case (off_q)
            2'd0:    lane_byte = MemRdata[7:0];
            2'd1:    lane_byte = MemRdata[15:8];
            2'd2:    lane_byte = MemRdata[23:16];
            default: lane_byte = MemRdata[31:24];
        endcase
        lane_half = off_q[1] ? MemRdata[31:16] : MemRdata[15:0];
        case (size_q)
            SZ_BYTE: load_data = {{24{signed_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_data = {{16{signed_q & lane_half[15]}}, lane_half};
            default: load_data = MemRdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic timeout;

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            IDLE: if (Valid && is_mem && !misaligned) state_d = WAIT;
            WAIT: begin
                // An ack on the last allowed cycle still completes normally.
                if (MemAck) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request qualifiers are decoded straight from state so reset drops them
    // without waiting for a clock edge.
    assign Busy   = (state_q != IDLE);
    assign MemReq = (state_q == WAIT);
    assign MemWE  = MemReq & store_q;

    // ------------------------------------------------------------------
    // Datapath registers and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q    <= '0;
            store_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SZ_WORD;
            off_q    <= 2'b00;
            MemAddr  <= '0;
            MemBE    <= '0;
            MemWdata <= '0;
            WBdata   <= '0;
            WBvalid  <= 1'b0;
            AddrErr  <= 1'b0;
            BusErr   <= 1'b0;
        end else begin
            WBvalid <= 1'b0;
            AddrErr <= 1'b0;
            BusErr  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Valid) begin
                        if (!is_mem) begin
                            WBdata  <= Result;
                            WBvalid <= 1'b1;
                        end else if (misaligned) begin
                            AddrErr <= 1'b1;
                        end else begin
                            cnt_q    <= '0;
                            store_q  <= is_store;
                            signed_q <= is_signed;
                            size_q   <= size;
                            off_q    <= Result[1:0];
                            MemAddr  <= {Result[31:2], 2'b00};
                            MemBE    <= be_d;
                            MemWdata <= wdata_d;
                        end
                    end
                end
                WAIT: begin
                    if (MemAck) begin
                        // WBvalid lands in DONE, one cycle after the ack.
                        if (!store_q) begin
                            WBdata  <= load_data;
                            WBvalid <= 1'b1;
                        end
                    end else if (timeout) begin
                        BusErr <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max cycles MemReq waits for MemAck before bus error.
REQ-002 SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Valid  input  1  EX result valid this cycle.
REQ-005 SHALL have port Ins  input  32  instruction; opcode Ins[31:26].
REQ-006 SHALL have port Result  input  32  EX result; effective address for loads/stores.
REQ-007 SHALL have port Rdata2  input  32  store data (rt).
REQ-008 SHALL have port Busy  output  1  stage occupied; upstream holds its outputs.
REQ-009 SHALL have port MemReq / MemWE  output  1 each  memory request, write enable.
REQ-010 SHALL have port MemAddr  output  32  word address, {Result[31:2],2'b00}.
REQ-011 SHALL have port MemBE  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-012 SHALL have port MemWdata  output  32  store data replicated into lanes.
REQ-013 SHALL have port MemAck  input  1  memory completion; MemRdata valid same cycle.
REQ-014 SHALL have port MemRdata  input  32  read data.
REQ-015 SHALL have port WBdata  output  32, WBvalid  output  1  writeback data and one-cycle strobe.
REQ-016 SHALL have port AddrErr / BusErr  output  1 each  one-cycle misalignment / timeout strobes.

Function
REQ-017 SHALL decode LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; other opcodes are non-memory.
REQ-018 SHALL implement states IDLE, WAIT, DONE; Valid sampled only in IDLE, ignored otherwise.
REQ-019 SHALL, for Valid non-memory op in IDLE, register WBdata=Result and pulse WBvalid next cycle; state stays IDLE (latency 1).
REQ-020 SHALL treat LH/LHU/SH with Result[0]=1 and LW/SW with Result[1:0]!=0 as misaligned: pulse AddrErr next cycle, no MemReq, no WBvalid, stay IDLE.
REQ-021 SHALL, for aligned memory op, latch address/data/opcode and enter WAIT; MemReq=1 from next cycle until the cycle MemAck=1.
REQ-022 SHALL drive MemBE: word 1111; half 0011 or 1100 per Result[1]; byte one-hot at lane Result[1:0]; MemWE=1 for stores only.
REQ-023 SHALL place store byte in all 4 lanes, store half in both halves; MemWdata/MemAddr/MemBE held stable while MemReq=1.
REQ-024 SHALL, on MemAck in WAIT, deassert MemReq next cycle, enter DONE; in DONE pulse WBvalid for loads only, then return to IDLE.
REQ-025 SHALL extract load data from selected lane; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-026 SHALL assert Busy when state!=IDLE; Busy=0 in DONE's successor cycle so a new op is accepted back-to-back.
REQ-027 SHALL count WAIT cycles; if count reaches TIMEOUT without MemAck, drop MemReq, pulse BusErr, return IDLE, no WBvalid.
REQ-028 SHALL ignore MemAck outside WAIT.
REQ-029 SHALL keep WBdata holding last value when WBvalid=0.

Reset
REQ-030 SHALL, on RST=0 at any time including mid-WAIT, immediately force state IDLE, MemReq=0, MemWE=0, MemBE=0, MemAddr=0, MemWdata=0, WBdata=0, WBvalid=0, Busy=0, AddrErr=0, BusErr=0, timeout counter 0.
REQ-031 SHALL resume normal operation on first rising edge after RST returns to 1.

Verification
REQ-032 SHALL test: Valid, ADD op, Result=0x2A -> next cycle WBdata=0x2A, WBvalid=1 for one cycle, MemReq=0.
REQ-033 SHALL test: LB Result=0x103, MemRdata=0x80FF_FFFF, MemAck after 3 cycles -> MemAddr=0x100, MemBE=1000, WBdata=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-034 SHALL test: SH Result=0x202, Rdata2=0x1234_ABCD -> MemAddr=0x200, MemBE=1100, MemWE=1, MemWdata=0xABCD_ABCD, no WBvalid.
REQ-035 SHALL test: LW Result=0x6 -> AddrErr pulse next cycle, MemReq never asserted, Busy stays 0.
REQ-036 SHALL test: SW with MemAck held 0 -> MemReq high exactly TIMEOUT=16 cycles, then BusErr pulse, Busy=0.
REQ-037 SHALL test: RST=0 asserted during WAIT -> MemReq/Busy drop without clock edge; later LW Result=0x10, MemRdata=0xDEADBEEF -> WBdata=0xDEADBEEF.
